// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor that replaces the static not-taken scheme.
// A direct-mapped BTB holds one entry per index. Each entry has a valid bit,
// a "jmp" flag for unconditional jumps, a tag, a target and a 2-bit
// saturating counter.
//
// The IF stage looks up the fetch PC combinationally and gets a predicted
// next PC back. The EX stage compares the resolved outcome with the
// prediction that travelled down the pipe with the instruction. On a
// mismatch it raises flush/flush_pc, and on the same clock edge it trains
// the table.
//
// Ports
//   clk, rst_n     clock and synchronous active-low reset
//   if_pc          PC being fetched
//   pred_taken     IF prediction: taken
//   pred_pc        IF predicted next PC
//   ex_valid       EX holds a real instruction
//   ex_npc_op      0=PC4, 1=BEQ, 2=JAL, 3=JALR
//   ex_br_taken    resolved outcome of the conditional branch
//   ex_pc          PC of the EX instruction
//   ex_target      resolved target address
//   ex_pred_taken  prediction carried with the instruction
//   ex_pred_pc     predicted next PC carried with the instruction
//   flush          squash IF/ID and redirect
//   flush_pc       redirect address
//   stat_br        resolved control instruction count
//   stat_miss      mispredict count
// ----------------------------------------------------------------------------
module branch_predictor #(
   parameter int         IDX_W     = 6,
   parameter int         TAG_W     = 8,
   parameter int         PRED_MODE = 1,
   parameter logic [1:0] CNT_RST   = 2'b01
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_pc,
   input  logic        ex_valid,
   input  logic [1:0]  ex_npc_op,
   input  logic        ex_br_taken,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_pc,
   output logic        flush,
   output logic [31:0] flush_pc,
   output logic [31:0] stat_br,
   output logic [31:0] stat_miss
);

   localparam int         ENTRIES  = 1 << IDX_W;
   localparam logic [1:0] NPC_PC4  = 2'd0;
   localparam logic [1:0] NPC_BEQ  = 2'd1;
   localparam logic [1:0] NPC_JAL  = 2'd2;
   localparam logic [1:0] NPC_JALR = 2'd3;

   logic [ENTRIES-1:0] valid_q;
   logic [ENTRIES-1:0] jmp_q;
   logic [1:0]         cnt_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];

   logic [IDX_W-1:0] if_idx, ex_idx;
   logic [TAG_W-1:0] if_tag, ex_tag;
   logic             if_hit, ex_hit;
   logic             is_beq, is_jmp, is_ctrl;
   logic             act_taken, mispredict;
   logic [31:0]      act_pc, ex_pc4;
   logic             upd_en, alloc, beq_train, alias_inval;
   logic [1:0]       cnt_sat;

   // IF lookup. It reads only registered state, so a lookup in the same
   // cycle as an update sees the old entry. Reset and static mode both
   // force a miss.
   always_comb begin
      if_idx     = if_pc[IDX_W+1:2];
      if_tag     = if_pc[IDX_W+TAG_W+1:IDX_W+2];
      if_hit     = (PRED_MODE == 1) && rst_n && valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      pred_taken = if_hit && (jmp_q[if_idx] || cnt_q[if_idx][1]);
      pred_pc    = pred_taken ? target_q[if_idx] : if_pc + 32'd4;
   end

   // EX resolution. A non-control instruction that was predicted taken
   // (a BTB alias) resolves to not-taken. The mispredict term then
   // redirects it to ex_pc+4.
   always_comb begin
      ex_pc4     = ex_pc + 32'd4;
      is_beq     = (ex_npc_op == NPC_BEQ);
      is_jmp     = (ex_npc_op == NPC_JAL) || (ex_npc_op == NPC_JALR);
      is_ctrl    = (ex_npc_op != NPC_PC4);
      act_taken  = is_jmp || (is_beq && ex_br_taken);
      act_pc     = act_taken ? ex_target : ex_pc4;
      mispredict = (act_taken != ex_pred_taken) || (act_taken && (ex_target != ex_pred_pc));
      flush      = rst_n && ex_valid && mispredict;
      flush_pc   = ex_valid ? act_pc : ex_pc4;
   end

   // Training decisions for the entry the EX instruction maps to. Taken
   // branches and jumps allocate over any occupant. Hits on BEQ only move
   // the counter (and the target when taken). Aliased non-control hits
   // drop the entry.
   always_comb begin
      ex_idx      = ex_pc[IDX_W+1:2];
      ex_tag      = ex_pc[IDX_W+TAG_W+1:IDX_W+2];
      ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
      upd_en      = rst_n && ex_valid && (PRED_MODE == 1);
      alloc       = upd_en && (is_jmp || (is_beq && !ex_hit && ex_br_taken));
      beq_train   = upd_en && is_beq && ex_hit;
      alias_inval = upd_en && (ex_npc_op == NPC_PC4) && ex_pred_taken && ex_hit;
      cnt_sat     = cnt_q[ex_idx];
      if (ex_br_taken && cnt_q[ex_idx] != 2'b11) begin
         cnt_sat = cnt_q[ex_idx] + 2'b01;
      end else if (!ex_br_taken && cnt_q[ex_idx] != 2'b00) begin
         cnt_sat = cnt_q[ex_idx] - 2'b01;
      end
   end

   // Control bits and statistics. Reset clears the valid/jmp/cnt bits and
   // the counters, and it takes priority over any update in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            jmp_q[i]   <= 1'b0;
            cnt_q[i]   <= CNT_RST;
         end
         stat_br   <= 32'd0;
         stat_miss <= 32'd0;
      end else begin
         if (ex_valid) begin
            stat_br   <= stat_br + 32'(is_ctrl);
            stat_miss <= stat_miss + 32'(flush);
         end
         if (alloc) begin
            valid_q[ex_idx] <= 1'b1;
            jmp_q[ex_idx]   <= is_jmp;
            if (is_beq) begin
               cnt_q[ex_idx] <= 2'b10;
            end
         end else if (beq_train) begin
            cnt_q[ex_idx] <= cnt_sat;
         end else if (alias_inval) begin
            valid_q[ex_idx] <= 1'b0;
         end
      end
   end

   // Tag and target storage. Reset leaves these untouched. The alloc and
   // beq_train enables already include rst_n, so a reset cycle writes nothing.
   always_ff @(posedge clk) begin
      if (alloc) begin
         tag_q[ex_idx]    <= ex_tag;
         target_q[ex_idx] <= ex_target;
      end else if (beq_train && ex_br_taken) begin
         target_q[ex_idx] <= ex_target;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed test for branch_predictor. A table of per-cycle vectors walks the
// BEQ allocation and counter training, the alias invalidation, JALR target
// retraining and bubbles. Hand-written sequences then cover reset racing
// an update.
// ----------------------------------------------------------------------------
module tb_branch_predictor;

   logic        clk;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_pc;
   logic        ex_valid;
   logic [1:0]  ex_npc_op;
   logic        ex_br_taken;
   logic [31:0] ex_pc;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_pc;
   logic        flush;
   logic [31:0] flush_pc;
   logic [31:0] stat_br;
   logic [31:0] stat_miss;

   localparam logic [1:0] PC4  = 2'd0;
   localparam logic [1:0] BEQ  = 2'd1;
   localparam logic [1:0] JAL  = 2'd2;
   localparam logic [1:0] JALR = 2'd3;

   int checkCount = 0;
   int errorCount = 0;

   branch_predictor dut (
      .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
      .pred_taken(pred_taken), .pred_pc(pred_pc),
      .ex_valid(ex_valid), .ex_npc_op(ex_npc_op), .ex_br_taken(ex_br_taken),
      .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
      .ex_pred_pc(ex_pred_pc), .flush(flush), .flush_pc(flush_pc),
      .stat_br(stat_br), .stat_miss(stat_miss)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ifPc;
      logic        exValid;
      logic [1:0]  op;
      logic        brTaken;
      logic [31:0] exPc;
      logic [31:0] exTarget;
      logic        exPredTaken;
      logic [31:0] exPredPc;
      logic        expPredTaken;
      logic [31:0] expPredPc;
      logic        expFlush;
      logic [31:0] expFlushPc;
      logic [31:0] expBr;
      logic [31:0] expMiss;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkVec(
      input logic [31:0] ifPc, input logic exValid, input logic [1:0] op,
      input logic brTaken, input logic [31:0] exPc, input logic [31:0] exTarget,
      input logic exPredTaken, input logic [31:0] exPredPc,
      input logic expPredTaken, input logic [31:0] expPredPc,
      input logic expFlush, input logic [31:0] expFlushPc,
      input logic [31:0] expBr, input logic [31:0] expMiss);
      vec_t v;
      v.ifPc = ifPc; v.exValid = exValid; v.op = op; v.brTaken = brTaken;
      v.exPc = exPc; v.exTarget = exTarget; v.exPredTaken = exPredTaken;
      v.exPredPc = exPredPc; v.expPredTaken = expPredTaken; v.expPredPc = expPredPc;
      v.expFlush = expFlush; v.expFlushPc = expFlushPc; v.expBr = expBr; v.expMiss = expMiss;
      return v;
   endfunction

   // Inputs change on the falling edge. Outputs are then sampled 1 ns later,
   // well away from the rising edge that commits the update.
   task automatic applyStimulus(input logic rst, input vec_t v);
      @(negedge clk);
      rst_n         = rst;
      if_pc         = v.ifPc;
      ex_valid      = v.exValid;
      ex_npc_op     = v.op;
      ex_br_taken   = v.brTaken;
      ex_pc         = v.exPc;
      ex_target     = v.exTarget;
      ex_pred_taken = v.exPredTaken;
      ex_pred_pc    = v.exPredPc;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic checkVec(input string tag, input vec_t v, input logic withStats);
      checkOutput({tag, " pred_taken"}, 32'(pred_taken), 32'(v.expPredTaken));
      checkOutput({tag, " pred_pc"},    pred_pc,         v.expPredPc);
      checkOutput({tag, " flush"},      32'(flush),      32'(v.expFlush));
      checkOutput({tag, " flush_pc"},   flush_pc,        v.expFlushPc);
      if (withStats) begin
         checkOutput({tag, " stat_br"},   stat_br,   v.expBr);
         checkOutput({tag, " stat_miss"}, stat_miss, v.expMiss);
      end
   endtask

   initial begin
      vec_t v;

      // 0x100 and 0x200 share index 0 (tags 0x01 / 0x02); 0x104 is index 1.
      // Stat expectations are the values before this row's clock edge.
      //                ifPc    vld op    brT exPc    exTgt   ePT eppc    xPT xPPC    xFl xFPC    br miss
      vecs.push_back(mkVec(32'h100, 0, BEQ,  1, 32'h100, 32'h140, 0, 32'h104, 0, 32'h104, 0, 32'h104, 0, 0)); // bubble hides mispredict
      vecs.push_back(mkVec(32'h100, 1, BEQ,  1, 32'h100, 32'h140, 0, 32'h104, 0, 32'h104, 1, 32'h140, 0, 0)); // alloc cnt=10
      vecs.push_back(mkVec(32'h100, 1, BEQ,  1, 32'h100, 32'h140, 1, 32'h140, 1, 32'h140, 0, 32'h140, 1, 1)); // cnt 10->11
      vecs.push_back(mkVec(32'h100, 1, BEQ,  1, 32'h100, 32'h140, 1, 32'h140, 1, 32'h140, 0, 32'h140, 2, 1)); // cnt 11 stays
      vecs.push_back(mkVec(32'h100, 1, BEQ,  0, 32'h100, 32'h140, 1, 32'h140, 1, 32'h140, 1, 32'h104, 3, 1)); // cnt 11->10
      vecs.push_back(mkVec(32'h100, 0, BEQ,  0, 32'h100, 32'h140, 1, 32'h140, 1, 32'h140, 0, 32'h104, 4, 2)); // bubble, cnt 10 kept
      vecs.push_back(mkVec(32'h100, 1, BEQ,  0, 32'h100, 32'h140, 1, 32'h140, 1, 32'h140, 1, 32'h104, 4, 2)); // cnt 10->01
      vecs.push_back(mkVec(32'h100, 1, PC4,  0, 32'h108, 32'h0,   0, 32'h10c, 0, 32'h104, 0, 32'h10c, 5, 3)); // weak NT: no prediction
      vecs.push_back(mkVec(32'h200, 1, BEQ,  1, 32'h200, 32'h280, 0, 32'h204, 0, 32'h204, 1, 32'h280, 5, 3)); // alias misses, reallocates
      vecs.push_back(mkVec(32'h100, 0, PC4,  0, 32'h200, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h204, 6, 4)); // old tag evicted
      vecs.push_back(mkVec(32'h200, 0, PC4,  0, 32'h200, 32'h0,   0, 32'h0,   1, 32'h280, 0, 32'h204, 6, 4)); // new owner predicts
      vecs.push_back(mkVec(32'h200, 1, JALR, 0, 32'h200, 32'h300, 1, 32'h280, 1, 32'h280, 1, 32'h300, 6, 4)); // JALR first pass
      vecs.push_back(mkVec(32'h200, 1, JALR, 0, 32'h200, 32'h380, 1, 32'h300, 1, 32'h300, 1, 32'h380, 7, 5)); // JALR retarget
      vecs.push_back(mkVec(32'h200, 1, JAL,  0, 32'h200, 32'h380, 1, 32'h380, 1, 32'h380, 0, 32'h380, 8, 6)); // correct jump
      vecs.push_back(mkVec(32'h200, 1, PC4,  0, 32'h200, 32'h0,   1, 32'h380, 1, 32'h380, 1, 32'h204, 9, 6)); // alias: invalidate
      vecs.push_back(mkVec(32'h200, 0, PC4,  0, 32'h200, 32'h0,   0, 32'h0,   0, 32'h204, 0, 32'h204, 9, 7)); // entry gone
      vecs.push_back(mkVec(32'h104, 1, BEQ,  0, 32'h104, 32'h150, 0, 32'h108, 0, 32'h108, 0, 32'h108, 9, 7)); // NT miss: no write
      vecs.push_back(mkVec(32'h104, 0, PC4,  0, 32'h104, 32'h0,   0, 32'h0,   0, 32'h108, 0, 32'h108,10, 7)); // still miss

      // Hold reset for two edges with a quiet EX stage.
      v = mkVec(32'h100, 0, PC4, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h104, 0, 32'h4, 0, 0);
      applyStimulus(1'b0, v);
      checkVec("reset", v, 1'b0);
      applyStimulus(1'b0, v);

      foreach (vecs[i]) begin
         applyStimulus(1'b1, vecs[i]);
         checkVec($sformatf("vec%0d", i), vecs[i], 1'b1);
      end

      // Reset racing a taken BEQ. First allocate 0x400 (index 0, tag 0x04)
      // so that there is a live entry for reset to clear.
      v = mkVec(32'h400, 1, BEQ, 1, 32'h400, 32'h440, 0, 32'h404, 0, 32'h404, 1, 32'h440, 10, 7);
      applyStimulus(1'b1, v);
      checkVec("rst-pre alloc", v, 1'b1);
      v = mkVec(32'h400, 0, PC4, 0, 32'h400, 32'h0, 0, 32'h0, 1, 32'h440, 0, 32'h404, 11, 8);
      applyStimulus(1'b1, v);
      checkVec("rst-pre hit", v, 1'b1);
      // In reset: the prediction is suppressed and the taken BEQ must not write.
      v = mkVec(32'h400, 1, BEQ, 1, 32'h104, 32'h150, 0, 32'h108, 0, 32'h404, 0, 32'h150, 0, 0);
      applyStimulus(1'b0, v);
      checkVec("rst-race", v, 1'b0);
      v = mkVec(32'h400, 0, PC4, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h404, 0, 32'h4, 0, 0);
      applyStimulus(1'b1, v);
      checkVec("rst-after 0x400", v, 1'b1);
      v = mkVec(32'h104, 0, PC4, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h108, 0, 32'h4, 0, 0);
      applyStimulus(1'b1, v);
      checkVec("rst-after 0x104", v, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
